// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
// Requester identity plus RAM data/lane geometry.
package ram_arb_pkg;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_id_t;

    localparam int unsigned RAM_DATAWIDTH = 16;
    localparam int unsigned RAM_LANES     = 2;

    // A request with any byte lane enabled targets the write port.
    function automatic logic is_write(input logic [RAM_LANES-1:0] we);
        return |we;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_arb2.sv
// Two-way priority arbiter (hi wins) with an optional starvation counter for lo.
// Starvation forcing is built only when RAM_ARB_FAIRNESS_EN is defined.
module arb2 #(
    parameter int unsigned MAXWAIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic req_hi,
    input  logic req_lo,
    output logic gnt_hi,
    output logic gnt_lo
);

`ifdef RAM_ARB_FAIRNESS_EN
    localparam int unsigned WAITW = (MAXWAIT > 0) ? $clog2(MAXWAIT + 1) : 1;

    logic [WAITW-1:0] wait_q, wait_d;
    logic             force_lo;

    assign force_lo = (wait_q == WAITW'(MAXWAIT));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        gnt_hi = 1'b0;
        gnt_lo = 1'b0;
        if (!reset) begin
            if (req_lo && (!req_hi || force_lo)) begin
                gnt_lo = 1'b1;
            end else begin
                gnt_hi = req_hi;
            end
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (gnt_lo) begin
            wait_d = '0;
        end else if (req_lo && !force_lo) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_cfg;

    assign gnt_hi     = !reset && req_hi;
    assign gnt_lo     = !reset && req_lo && !req_hi;
    assign unused_cfg = clk ^ (MAXWAIT == 0);
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the CPU (primary) and DMA (secondary) onto the data RAM's read and write ports.
// Define RAM_ARB_FAIRNESS_EN to build the MAXWAIT anti-starvation counters.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDRBITS = 10,
    parameter int unsigned MAXWAIT  = 3
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cpu_req,
    input  logic [RAM_LANES-1:0]     cpu_we,
    input  logic [15:0]              cpu_addr,
    input  logic [RAM_DATAWIDTH-1:0] cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    output logic [RAM_DATAWIDTH-1:0] cpu_rdata,

    input  logic                     dma_req,
    input  logic [RAM_LANES-1:0]     dma_we,
    input  logic [15:0]              dma_addr,
    input  logic [RAM_DATAWIDTH-1:0] dma_wdata,
    output logic                     dma_gnt,
    output logic                     dma_rvalid,
    output logic [RAM_DATAWIDTH-1:0] dma_rdata,

    output logic [15:0]              dread_addr,
    input  logic [RAM_DATAWIDTH-1:0] dread_data,
    output logic [15:0]              dwrite_addr,
    output logic [RAM_DATAWIDTH-1:0] dwrite_data,
    output logic [RAM_LANES-1:0]     dwrite_en
);

    logic    cpu_rd_req, cpu_wr_req, dma_rd_req, dma_wr_req;
    logic    cpu_rd_gnt, cpu_wr_gnt, dma_rd_gnt, dma_wr_gnt;
    req_id_t owner_q, owner_d;
    logic    valid_q, valid_d;
    logic    rd_live;
    logic    unused_cfg;

    assign cpu_rd_req = cpu_req && !is_write(cpu_we);
    assign cpu_wr_req = cpu_req &&  is_write(cpu_we);
    assign dma_rd_req = dma_req && !is_write(dma_we);
    assign dma_wr_req = dma_req &&  is_write(dma_we);

    arb2 #(.MAXWAIT(MAXWAIT)) u_rd_arb (
        .clk    (clk),
        .reset  (reset),
        .req_hi (cpu_rd_req),
        .req_lo (dma_rd_req),
        .gnt_hi (cpu_rd_gnt),
        .gnt_lo (dma_rd_gnt)
    );

    arb2 #(.MAXWAIT(MAXWAIT)) u_wr_arb (
        .clk    (clk),
        .reset  (reset),
        .req_hi (cpu_wr_req),
        .req_lo (dma_wr_req),
        .gnt_hi (cpu_wr_gnt),
        .gnt_lo (dma_wr_gnt)
    );

    assign cpu_gnt = cpu_rd_gnt | cpu_wr_gnt;
    assign dma_gnt = dma_rd_gnt | dma_wr_gnt;

    // Idle ports present the CPU's fields so the RAM pins stay quiet and predictable.
    always_comb begin
        dwrite_en   = '0;
        dwrite_addr = cpu_addr;
        dwrite_data = cpu_wdata;
        if (dma_wr_gnt) begin
            dwrite_en   = dma_we;
            dwrite_addr = dma_addr;
            dwrite_data = dma_wdata;
        end else if (cpu_wr_gnt) begin
            dwrite_en   = cpu_we;
        end
    end

    assign dread_addr = dma_rd_gnt ? dma_addr : cpu_addr;

    always_comb begin
        owner_d = owner_q;
        if (dma_rd_gnt) begin
            owner_d = REQ_DMA;
        end else if (cpu_rd_gnt) begin
            owner_d = REQ_CPU;
        end
    end

    assign valid_d = cpu_rd_gnt | dma_rd_gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= REQ_CPU;
            valid_q <= 1'b0;
        end else begin
            owner_q <= owner_d;
            valid_q <= valid_d;
        end
    end

    // Reset arriving while a read is in flight must squash its return immediately.
    assign rd_live    = valid_q && !reset;
    assign cpu_rvalid = rd_live && (owner_q == REQ_CPU);
    assign dma_rvalid = rd_live && (owner_q == REQ_DMA);
    assign cpu_rdata  = rd_live ? dread_data : '0;
    assign dma_rdata  = rd_live ? dread_data : '0;

    assign unused_cfg = (ADDRBITS == 0);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a byte-addressed RAM model.
module tb_ram_port_arbiter;

`ifdef RAM_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, dma_req;
    logic [1:0]  cpu_we, dma_we;
    logic [15:0] cpu_addr, dma_addr, cpu_wdata, dma_wdata;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic [15:0] cpu_rdata, dma_rdata;
    logic [15:0] dread_addr, dread_data, dwrite_addr, dwrite_data;
    logic [1:0]  dwrite_en;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDRBITS(10), .MAXWAIT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_gnt     (dma_gnt),
        .dma_rvalid  (dma_rvalid),
        .dma_rdata   (dma_rdata),
        .dread_addr  (dread_addr),
        .dread_data  (dread_data),
        .dwrite_addr (dwrite_addr),
        .dwrite_data (dwrite_data),
        .dwrite_en   (dwrite_en)
    );

    // Byte-addressed RAM: lane 0 lands at addr, lane 1 at addr+1; synchronous read, write-through.
    logic [7:0] mem [0:65535];

    function automatic logic [7:0] rd_byte(input logic [15:0] a);
        logic [7:0] b;
        b = mem[a];
        if (dwrite_en[0] && dwrite_addr == a) b = dwrite_data[7:0];
        if (dwrite_en[1] && (dwrite_addr + 16'd1) == a) b = dwrite_data[15:8];
        return b;
    endfunction

    always @(posedge clk) begin
        if (dwrite_en[0]) mem[dwrite_addr] <= dwrite_data[7:0];
        if (dwrite_en[1]) mem[dwrite_addr + 16'd1] <= dwrite_data[15:8];
        dread_data <= {rd_byte(dread_addr + 16'd1), rd_byte(dread_addr)};
    end

    typedef struct {
        logic        rst;
        logic        c_req;
        logic [1:0]  c_we;
        logic [15:0] c_addr;
        logic [15:0] c_wdata;
        logic        d_req;
        logic [1:0]  d_we;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        e_cgnt;
        logic        e_dgnt;
        logic [1:0]  e_wen;
        logic [15:0] e_waddr;
        logic [15:0] e_raddr;
        logic        e_crv;
        logic        e_drv;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(
        input logic rst,
        input logic c_req, input logic [1:0] c_we, input logic [15:0] c_addr, input logic [15:0] c_wdata,
        input logic d_req, input logic [1:0] d_we, input logic [15:0] d_addr, input logic [15:0] d_wdata,
        input logic e_cgnt, input logic e_dgnt, input logic [1:0] e_wen,
        input logic [15:0] e_waddr, input logic [15:0] e_raddr,
        input logic e_crv, input logic e_drv, input logic [15:0] e_rdata);
        vec_t r;
        r.rst = rst;
        r.c_req = c_req; r.c_we = c_we; r.c_addr = c_addr; r.c_wdata = c_wdata;
        r.d_req = d_req; r.d_we = d_we; r.d_addr = d_addr; r.d_wdata = d_wdata;
        r.e_cgnt = e_cgnt; r.e_dgnt = e_dgnt; r.e_wen = e_wen;
        r.e_waddr = e_waddr; r.e_raddr = e_raddr;
        r.e_crv = e_crv; r.e_drv = e_drv; r.e_rdata = e_rdata;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(
        input logic rst,
        input logic creq, input logic [1:0] cwe, input logic [15:0] caddr, input logic [15:0] cwd,
        input logic dreq, input logic [1:0] dwe, input logic [15:0] daddr, input logic [15:0] dwd);
        reset     = rst;
        cpu_req   = creq;  cpu_we = cwe;  cpu_addr = caddr;  cpu_wdata = cwd;
        dma_req   = dreq;  dma_we = dwe;  dma_addr = daddr;  dma_wdata = dwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem[16'h3C10] <= 8'hEF; mem[16'h3C11] <= 8'hBE;
        mem[16'h3C20] <= 8'h55; mem[16'h3C21] <= 8'h55;
        mem[16'h3C30] <= 8'h77; mem[16'h3C31] <= 8'h66;
        mem[16'h3C32] <= 8'h99; mem[16'h3C33] <= 8'h88;
        mem[16'h3C40] <= 8'h11; mem[16'h3C41] <= 8'h11;
        mem[16'h3C42] <= 8'h22; mem[16'h3C43] <= 8'h22;
        mem[16'h3C44] <= 8'h33; mem[16'h3C45] <= 8'h33;
        mem[16'h3C46] <= 8'h44; mem[16'h3C47] <= 8'h44;
        mem[16'h3C60] <= 8'h5A; mem[16'h3C61] <= 8'h00;

        //            rst creq cwe caddr     cwdata    dreq dwe daddr     dwdata    cg dg wen  waddr     raddr     crv drv rdata
        vq.push_back(v(1, 1, 2'd0, 16'h3C10, 16'h0000, 1, 2'd3, 16'h3C20, 16'h1234, 0, 0, 2'd0, 16'h3C10, 16'h3C10, 0, 0, 16'h0000));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 16'h0000));
        vq.push_back(v(0, 1, 2'd0, 16'h3C10, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 2'd0, 16'h3C10, 16'h3C10, 0, 0, 16'h0000));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'hBEEF));
        vq.push_back(v(0, 1, 2'd0, 16'h3C20, 16'h0000, 1, 2'd3, 16'h3C20, 16'h1234, 1, 1, 2'd3, 16'h3C20, 16'h3C20, 0, 0, 16'h0000));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'h1234));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 1, 2'd1, 16'h3C31, 16'h00AA, 0, 1, 2'd1, 16'h3C31, 16'h0000, 0, 0, 16'h0000));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 1, 2'd0, 16'h3C30, 16'h0000, 0, 1, 2'd0, 16'h0000, 16'h3C30, 0, 0, 16'h0000));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 1, 2'd0, 16'h3C32, 16'h0000, 0, 1, 2'd0, 16'h0000, 16'h3C32, 0, 1, 16'hAA77));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 0, 1, 16'h8899));
        vq.push_back(v(0, 1, 2'd0, 16'h3C40, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 2'd0, 16'h3C40, 16'h3C40, 0, 0, 16'h0000));
        vq.push_back(v(0, 1, 2'd0, 16'h3C42, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 2'd0, 16'h3C42, 16'h3C42, 1, 0, 16'h1111));
        vq.push_back(v(0, 1, 2'd0, 16'h3C44, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 2'd0, 16'h3C44, 16'h3C44, 1, 0, 16'h2222));
        vq.push_back(v(0, 1, 2'd0, 16'h3C46, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 2'd0, 16'h3C46, 16'h3C46, 1, 0, 16'h3333));
        vq.push_back(v(0, 1, 2'd2, 16'h3C60, 16'hAB00, 1, 2'd0, 16'h3C40, 16'h0000, 1, 1, 2'd2, 16'h3C60, 16'h3C40, 1, 0, 16'h4444));
        vq.push_back(v(0, 1, 2'd0, 16'h3C60, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 2'd0, 16'h3C60, 16'h3C60, 0, 1, 16'h1111));
        vq.push_back(v(0, 0, 2'd0, 16'h0000, 16'h0000, 0, 2'd0, 16'h0000, 16'h0000, 0, 0, 2'd0, 16'h0000, 16'h0000, 1, 0, 16'hAB5A));

        drive(1, 0, 2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0);
        next_cycle();

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].c_req, vq[i].c_we, vq[i].c_addr, vq[i].c_wdata,
                  vq[i].d_req, vq[i].d_we, vq[i].d_addr, vq[i].d_wdata);
            @(negedge clk);
            check($sformatf("v%0d cpu_gnt", i),     cpu_gnt,     vq[i].e_cgnt);
            check($sformatf("v%0d dma_gnt", i),     dma_gnt,     vq[i].e_dgnt);
            check($sformatf("v%0d dwrite_en", i),   dwrite_en,   vq[i].e_wen);
            check($sformatf("v%0d dwrite_addr", i), dwrite_addr, vq[i].e_waddr);
            check($sformatf("v%0d dread_addr", i),  dread_addr,  vq[i].e_raddr);
            check($sformatf("v%0d cpu_rvalid", i),  cpu_rvalid,  vq[i].e_crv);
            check($sformatf("v%0d dma_rvalid", i),  dma_rvalid,  vq[i].e_drv);
            if (vq[i].e_crv) check($sformatf("v%0d cpu_rdata", i), cpu_rdata, vq[i].e_rdata);
            if (vq[i].e_drv) check($sformatf("v%0d dma_rdata", i), dma_rdata, vq[i].e_rdata);
            if (!vq[i].e_crv && !vq[i].e_drv) begin
                check($sformatf("v%0d cpu_rdata idle", i), cpu_rdata, 16'h0000);
                check($sformatf("v%0d dma_rdata idle", i), dma_rdata, 16'h0000);
            end
            next_cycle();
        end

        // Continuous contention on each port: DMA forced through on the 4th cycle only with fairness.
        for (int port = 0; port < 2; port++) begin
            drive(1, 0, 2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0);
            next_cycle();
            for (int c = 0; c < 6; c++) begin
                if (port == 0)
                    drive(0, 1, 2'd3, 16'h3C70, 16'h0101, 1, 2'd3, 16'h3C72, 16'h0202);
                else
                    drive(0, 1, 2'd0, 16'h3C40, 16'h0000, 1, 2'd0, 16'h3C42, 16'h0000);
                @(negedge clk);
                check($sformatf("contend p%0d c%0d dma_gnt", port, c), dma_gnt, FAIR && (c == 3));
                check($sformatf("contend p%0d c%0d cpu_gnt", port, c), cpu_gnt, !(FAIR && (c == 3)));
                if (port == 0)
                    check($sformatf("contend p%0d c%0d dwrite_addr", port, c), dwrite_addr,
                          (FAIR && (c == 3)) ? 16'h3C72 : 16'h3C70);
                else
                    check($sformatf("contend p%0d c%0d dread_addr", port, c), dread_addr,
                          (FAIR && (c == 3)) ? 16'h3C42 : 16'h3C40);
                next_cycle();
            end
        end

        // Reset lands in the cycle after a DMA read grant: its rvalid must never appear.
        drive(0, 0, 2'd0, 16'h0, 16'h0, 1, 2'd0, 16'h3C40, 16'h0);
        @(negedge clk);
        check("rst_rd dma_gnt before reset", dma_gnt, 1'b1);
        next_cycle();
        drive(1, 1, 2'd3, 16'h3C80, 16'hFFFF, 1, 2'd0, 16'h3C42, 16'h0);
        @(negedge clk);
        check("rst_rd dma_rvalid", dma_rvalid, 1'b0);
        check("rst_rd cpu_rvalid", cpu_rvalid, 1'b0);
        check("rst_rd cpu_gnt",    cpu_gnt,    1'b0);
        check("rst_rd dma_gnt",    dma_gnt,    1'b0);
        check("rst_rd dwrite_en",  dwrite_en,  2'b00);
        check("rst_rd cpu_rdata",  cpu_rdata,  16'h0000);
        check("rst_rd dma_rdata",  dma_rdata,  16'h0000);
        next_cycle();
        drive(0, 0, 2'd0, 16'h0, 16'h0, 0, 2'd0, 16'h0, 16'h0);
        @(negedge clk);
        check("post_rst dma_rvalid", dma_rvalid, 1'b0);
        check("post_rst cpu_rvalid", cpu_rvalid, 1'b0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
